wb_ram_arbiter: RTL and testbench

- Two-master Wishbone arbiter that shares one wb_ram slave port between requesters, e.g. CPU data port (m0) and a DMA/debug master (m1).
- Grants the slave for the whole duration of a master's cycle (cyc held), using round-robin priority when both masters request in the same cycle.
- Forwards stall/ack back to the granted master only.
- Includes an ack watchdog that aborts a hung cycle and signals error to the granted master.

---
 rtl/wb_ram_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of a single wb_ram slave port.
//
// A master owns the slave for its whole Wishbone cycle (cyc held). A tie in
// IDLE goes to the master that was not granted last. An ack watchdog aborts
// a hung cycle and reports err to the owning master.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   mN_cyc_i/stb_i/we_i          master N Wishbone control (N = 0, 1)
//   mN_sel_i/adr_i/dat_i/cti_i   master N byte selects, word address, write data, cycle type
//   mN_dat_o/ack_o/stall_o       slave responses routed to master N
//   mN_err_o                     one-cycle watchdog abort pulse to master N
//   s_cyc_o ... s_cti_o          request towards the slave
//   s_dat_i/ack_i/stall_i        slave responses
module wb_ram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADR_WIDTH      = 30
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [ADR_WIDTH-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic [2:0]           m0_cti_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_stall_o,
  output logic                 m0_err_o,

  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [ADR_WIDTH-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  input  logic [2:0]           m1_cti_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_stall_o,
  output logic                 m1_err_o,

  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [ADR_WIDTH-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [2:0]           s_cti_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_stall_i
);

  localparam int unsigned DAT_W    = 32;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned CTI_W    = 3;
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [SEL_W-1:0]     sel;
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_W-1:0]     dat;
    logic [CTI_W-1:0]     cti;
  } req_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] wd_cnt;
  logic             m0_err_q, m1_err_q;

  req_t             m0_req, m1_req, s_req;
  logic             gnt0, gnt1, granted;
  logic             own_cyc, own_stb;
  logic             abort;
  logic             wd_hit;

  // Bundle each master's payload so the slave mux is a single select.
  assign m0_req = '{we: m0_we_i, sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i, cti: m0_cti_i};
  assign m1_req = '{we: m1_we_i, sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i, cti: m1_cti_i};

  // Decode of the registered grant and the owning master's control lines.
  assign gnt0    = (state == GNT0);
  assign gnt1    = (state == GNT1);
  assign granted = gnt0 | gnt1;
  assign own_cyc = gnt1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = gnt1 ? m1_stb_i : m0_stb_i;
  assign abort   = m0_err_q | m1_err_q;

  // The last stalled strobe before the limit arms the abort for the next cycle.
  assign wd_hit = WD_EN && granted && own_cyc && own_stb && !s_ack_i && !abort
                  && (wd_cnt == CNT_W'(CNT_LAST));

  // Grant state and round-robin memory.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Arbitration: ties go to the master not granted last; a grant ends when
  // its owner drops cyc or the watchdog aborts, always passing through IDLE.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_grant) begin
            state_nxt      = GNT0;
            last_grant_nxt = 1'b0;
          end else begin
            state_nxt      = GNT1;
            last_grant_nxt = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || m0_err_q) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || m1_err_q) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Ack watchdog: counts stalled strobes of the owner; cleared in IDLE and on ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt   <= '0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      if (!granted || s_ack_i) begin
        wd_cnt <= '0;
      end else if (WD_EN && own_stb) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      m0_err_q <= wd_hit & gnt0;
      m1_err_q <= wd_hit & gnt1;
    end
  end

  // Slave request mux; cyc/stb are withheld in IDLE and in the abort cycle.
  always_comb begin
    s_req   = m0_req;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (gnt1) begin
      s_req = m1_req;
    end
    if (granted && !abort) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb;
    end
  end

  assign s_we_o  = s_req.we;
  assign s_sel_o = s_req.sel;
  assign s_adr_o = s_req.adr;
  assign s_dat_o = s_req.dat;
  assign s_cti_o = s_req.cti;

  // Responses reach only the owner; ack is masked once the owner drops cyc.
  assign m0_ack_o   = s_ack_i & gnt0 & m0_cyc_i;
  assign m1_ack_o   = s_ack_i & gnt1 & m1_cyc_i;
  assign m0_stall_o = gnt0 ? s_stall_i : 1'b1;
  assign m1_stall_o = gnt1 ? s_stall_i : 1'b1;
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign m0_err_o   = m0_err_q;
  assign m1_err_o   = m1_err_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench for wb_ram_arbiter: directed master scripts, a small
// wb_ram-like slave, an ownership-level reference model compared every cycle,
// and literal expectations at the scenario points of interest.
module tb_wb_ram_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned TO = 16;
  localparam int unsigned FW = 1 + 4 + AW + 32 + 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]    m0_sel_i;
  logic [AW-1:0] m0_adr_i;
  logic [31:0]   m0_dat_i;
  logic [2:0]    m0_cti_i;
  logic [31:0]   m0_dat_o;
  logic          m0_ack_o, m0_stall_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]    m1_sel_i;
  logic [AW-1:0] m1_adr_i;
  logic [31:0]   m1_dat_i;
  logic [2:0]    m1_cti_i;
  logic [31:0]   m1_dat_o;
  logic          m1_ack_o, m1_stall_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [AW-1:0] s_adr_o;
  logic [31:0]   s_dat_o;
  logic [2:0]    s_cti_o;
  logic [31:0]   s_dat_i;
  logic          s_ack_i, s_stall_i;

  int checks   = 0;
  int failures = 0;

  wb_ram_arbiter #(.TIMEOUT_CYCLES(TO), .ADR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_cti_i(m0_cti_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_cti_i(m1_cti_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- slave
  logic [31:0]   mem [64];
  logic          slave_ok;
  logic          acc, a_we;
  logic [3:0]    a_sel;
  logic [AW-1:0] a_adr;
  logic [31:0]   a_dat;

  // Accepts a strobe seen on the falling edge and acks it in the next cycle.
  initial begin
    s_ack_i   = 1'b0;
    s_dat_i   = 32'h0;
    s_stall_i = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk_i);
      acc   = !rst_i && slave_ok && s_cyc_o && s_stb_o && !s_stall_i;
      a_we  = s_we_o;
      a_sel = s_sel_o;
      a_adr = s_adr_o;
      a_dat = s_dat_o;
      @(posedge clk_i);
      #1;
      s_ack_i = acc;
      s_dat_i = 32'h0;
      if (acc) begin
        if (a_we) begin
          for (int b = 0; b < 4; b++)
            if (a_sel[b]) mem[a_adr[5:0]][8*b +: 8] = a_dat[8*b +: 8];
        end else begin
          s_dat_i = mem[a_adr[5:0]];
        end
      end
    end
  end

  // ---------------------------------------------------------------- model
  // Ownership model: who holds the slave, who was served last, how many
  // stalled strobes the owner has issued, and whether this is the abort cycle.
  int             own  = -1;
  bit             last = 1'b1;
  int             wcnt = 0;
  bit             errf = 1'b0;
  logic           e_scyc, e_sstb, o_cyc, o_stb;
  logic [FW-1:0]  e_fields;

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        own = -1; last = 1'b1; wcnt = 0; errf = 1'b0;
      end
      o_cyc    = (own == 1) ? m1_cyc_i : m0_cyc_i;
      o_stb    = (own == 1) ? m1_stb_i : m0_stb_i;
      e_scyc   = (own >= 0) && o_cyc && !errf;
      e_sstb   = (own >= 0) && o_stb && !errf;
      e_fields = (own == 1) ? {m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i, m1_cti_i}
                            : {m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i, m0_cti_i};
      chk("s_cyc",    s_cyc_o, e_scyc);
      chk("s_stb",    s_stb_o, e_sstb);
      chk("s_fields", {s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o}, e_fields);
      chk("m0_ack",   m0_ack_o, s_ack_i && own == 0 && m0_cyc_i);
      chk("m1_ack",   m1_ack_o, s_ack_i && own == 1 && m1_cyc_i);
      chk("m0_stall", m0_stall_o, (own == 0) ? s_stall_i : 1'b1);
      chk("m1_stall", m1_stall_o, (own == 1) ? s_stall_i : 1'b1);
      chk("m0_err",   m0_err_o, errf && own == 0);
      chk("m1_err",   m1_err_o, errf && own == 1);
      chk("m_dat",    {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
      if (!rst_i) begin
        if (own < 0) begin
          if (m0_cyc_i && m1_cyc_i) own = last ? 0 : 1;
          else if (m0_cyc_i)        own = 0;
          else if (m1_cyc_i)        own = 1;
          if (own >= 0) last = (own == 1);
          wcnt = 0;
        end else if (errf) begin
          own = -1; errf = 1'b0; wcnt = 0;
        end else if (!o_cyc) begin
          own = -1; wcnt = 0;
        end else begin
          if (s_ack_i) wcnt = 0;
          else if (o_stb) wcnt++;
          if (TO != 0 && wcnt == TO) errf = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc_start();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv0(input logic cyc, input logic stb, input logic we, input logic [3:0] sel,
                      input logic [AW-1:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_sel_i = sel;
    m0_adr_i = adr; m0_dat_i = dat; m0_cti_i = cti;
  endtask

  task automatic drv1(input logic cyc, input logic stb, input logic we, input logic [3:0] sel,
                      input logic [AW-1:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_sel_i = sel;
    m1_adr_i = adr; m1_dat_i = dat; m1_cti_i = cti;
  endtask

  task automatic off0();
    drv0(1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 3'b000);
  endtask

  task automatic off1();
    drv1(1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 3'b000);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_start();
  endtask

  // Returns at a drive point with reset just released.
  task automatic do_reset();
    cyc_start();
    rst_i = 1'b1;
    off0(); off1();
    idle(2);
    rst_i = 1'b0;
  endtask

  int   err_cnt, err_at, m1_gnt_at;
  logic scyc_at_err;

  initial begin
    rst_i    = 1'b1;
    slave_ok = 1'b1;
    off0(); off1();

    // Reset values
    @(negedge clk_i);
    chk("rst_s_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    chk("rst_stalls",    {m0_stall_o, m1_stall_o}, 2'b11);
    chk("rst_ack_err",   {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
    cyc_start();
    rst_i = 1'b0;

    // Single master: write 0xDEADBEEF to 5, read it back
    idle(1);
    drv0(1'b1, 1'b1, 1'b1, 4'hF, 30'd5, 32'hDEADBEEF, 3'b000);
    @(negedge clk_i); chk("single_latency_idle", s_cyc_o, 1'b0);
    cyc_start();
    @(negedge clk_i); chk("single_s_cyc_rise", s_cyc_o, 1'b1);
    cyc_start(); drv0(1'b1, 1'b0, 1'b1, 4'hF, 30'd5, 32'hDEADBEEF, 3'b000);
    @(negedge clk_i); chk("single_wr_ack", m0_ack_o, 1'b1);
    cyc_start(); drv0(1'b1, 1'b1, 1'b0, 4'hF, 30'd5, 32'h0, 3'b000);
    cyc_start(); drv0(1'b1, 1'b0, 1'b0, 4'hF, 30'd5, 32'h0, 3'b000);
    @(negedge clk_i);
    chk("single_rd_ack",  m0_ack_o, 1'b1);
    chk("single_rd_data", m0_dat_o, 32'hDEADBEEF);
    chk("single_m1_noack", m1_ack_o, 1'b0);
    cyc_start(); off0();
    idle(2);

    // Simultaneous requests after reset: m0, one IDLE, m1, then m0 again
    do_reset();
    drv0(1'b1, 1'b1, 1'b1, 4'hF, 30'd7, 32'h1111_0000, 3'b000);
    drv1(1'b1, 1'b1, 1'b1, 4'hF, 30'd8, 32'h2222_0000, 3'b000);
    cyc_start();
    @(negedge clk_i); chk("tie1_m0_first", {m0_stall_o, m1_stall_o, s_adr_o}, {2'b01, 30'd7});
    cyc_start(); drv0(1'b1, 1'b0, 1'b1, 4'hF, 30'd7, 32'h1111_0000, 3'b000);
    cyc_start(); off0();
    cyc_start();
    @(negedge clk_i); chk("tie1_gap_idle", {m0_stall_o, m1_stall_o, s_cyc_o}, 3'b110);
    cyc_start();
    @(negedge clk_i); chk("tie1_m1_second", {m1_stall_o, s_adr_o}, {1'b0, 30'd8});
    cyc_start(); drv1(1'b1, 1'b0, 1'b1, 4'hF, 30'd8, 32'h2222_0000, 3'b000);
    @(negedge clk_i); chk("tie1_m1_ack", m1_ack_o, 1'b1);
    cyc_start(); off1();
    cyc_start();
    drv0(1'b1, 1'b1, 1'b0, 4'hF, 30'd7, 32'h0, 3'b000);
    drv1(1'b1, 1'b1, 1'b0, 4'hF, 30'd8, 32'h0, 3'b000);
    cyc_start();
    @(negedge clk_i); chk("tie2_m0_again", {m0_stall_o, m1_stall_o}, 2'b01);
    cyc_start(); drv0(1'b1, 1'b0, 1'b0, 4'hF, 30'd7, 32'h0, 3'b000);
    @(negedge clk_i); chk("tie2_rd_data", m0_dat_o, 32'h1111_0000);
    cyc_start(); off0(); off1();
    idle(3);

    // Contention: m1 arrives during a 4-beat incrementing burst of m0
    drv0(1'b1, 1'b1, 1'b1, 4'hF, 30'd16, 32'hB000_0000, 3'b010);
    for (int b = 0; b < 4; b++) begin
      cyc_start();
      if (b == 1) drv1(1'b1, 1'b1, 1'b0, 4'hF, 30'd17, 32'h0, 3'b000);
      if (b > 0) drv0(1'b1, 1'b1, 1'b1, 4'hF, AW'(16 + b), 32'hB000_0000 + 32'(b),
                      (b == 3) ? 3'b111 : 3'b010);
      @(negedge clk_i);
      chk("cont_m1_stalled", m1_stall_o, 1'b1);
      chk("cont_m0_beat",    m0_stall_o, 1'b0);
    end
    cyc_start(); drv0(1'b1, 1'b0, 1'b1, 4'hF, 30'd19, 32'hB000_0003, 3'b111);
    cyc_start(); off0();
    @(negedge clk_i); chk("cont_drop_cycle", {s_cyc_o, m1_stall_o}, 2'b01);
    cyc_start();
    @(negedge clk_i); chk("cont_gap_idle", {s_cyc_o, m1_stall_o}, 2'b01);
    cyc_start();
    @(negedge clk_i); chk("cont_m1_granted", {s_cyc_o, m1_stall_o, s_adr_o}, {2'b10, 30'd17});
    cyc_start(); drv1(1'b1, 1'b0, 1'b0, 4'hF, 30'd17, 32'h0, 3'b000);
    @(negedge clk_i); chk("cont_m1_rd_data", {m1_ack_o, m1_dat_o}, {1'b1, 32'hB000_0001});
    cyc_start(); off1();
    idle(3);

    // Watchdog: slave never acks m0
    slave_ok = 1'b0;
    drv0(1'b1, 1'b1, 1'b0, 4'hF, 30'd3, 32'h0, 3'b000);
    cyc_start();
    err_cnt = 0; err_at = -1; m1_gnt_at = -1; scyc_at_err = 1'bx;
    for (int k = 0; k < 24; k++) begin
      if (k == 2) drv1(1'b1, 1'b1, 1'b0, 4'hF, 30'd9, 32'h0, 3'b000);
      @(negedge clk_i);
      if (m0_err_o === 1'b1) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at      = k;
          scyc_at_err = s_cyc_o;
        end
      end
      if (m1_gnt_at < 0 && m1_stall_o === 1'b0) m1_gnt_at = k;
      cyc_start();
      if (err_at >= 0) begin
        off0();
        slave_ok = 1'b1;
      end
    end
    chk("wd_err_pulses",   32'(err_cnt), 32'd1);
    chk("wd_err_cycle",    32'(err_at), 32'd16);
    chk("wd_s_cyc_at_err", scyc_at_err, 1'b0);
    chk("wd_m1_grant_cyc", 32'(m1_gnt_at), 32'd18);
    off1();
    idle(3);

    // Reset during an m1 grant
    drv1(1'b1, 1'b1, 1'b0, 4'hF, 30'd9, 32'h0, 3'b000);
    cyc_start();
    @(negedge clk_i); chk("rstm_m1_granted", m1_stall_o, 1'b0);
    cyc_start();
    rst_i = 1'b1;
    #1;
    chk("rstm_async", {s_cyc_o, s_stb_o, m1_stall_o, m1_ack_o, m1_err_o}, 5'b00100);
    off1();
    @(negedge clk_i);
    cyc_start();
    rst_i = 1'b0;
    drv0(1'b1, 1'b1, 1'b0, 4'hF, 30'd5, 32'h0, 3'b000);
    drv1(1'b1, 1'b1, 1'b0, 4'hF, 30'd9, 32'h0, 3'b000);
    @(negedge clk_i); chk("rstm_release_idle", s_cyc_o, 1'b0);
    cyc_start();
    @(negedge clk_i); chk("rstm_tie_m0", {m0_stall_o, m1_stall_o}, 2'b01);
    cyc_start(); drv0(1'b1, 1'b0, 1'b0, 4'hF, 30'd5, 32'h0, 3'b000);
    cyc_start(); off0(); off1();
    idle(3);

    // Early cyc drop in the ack cycle
    drv0(1'b1, 1'b1, 1'b0, 4'hF, 30'd5, 32'h0, 3'b000);
    cyc_start();
    cyc_start(); off0();
    @(negedge clk_i);
    chk("early_ack_masked", m0_ack_o, 1'b0);
    chk("early_no_err",     m0_err_o, 1'b0);
    cyc_start();
    @(negedge clk_i); chk("early_back_idle", {s_cyc_o, m0_stall_o}, 2'b01);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout at %0t: got=running expected=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
